truth_table_sweeper: RTL and testbench



---
 rtl/tt_sweep_pkg.sv | 23 ++
 rtl/sync2.sv | 29 ++
 rtl/truth_table_sweeper.sv | 126 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Contents:
//   state_e - sweeper FSM states
//   TT_W    - truth table width (one bit per input row)
//   ROW_W   - row index width (three benchmark inputs)
//   row_bit - table bit holding a given row; row 000 maps to the MSB
package tt_sweep_pkg;

  localparam int unsigned TT_W  = 8;
  localparam int unsigned ROW_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  function automatic logic [ROW_W-1:0] row_bit(input logic [ROW_W-1:0] row);
    return ROW_W'(TT_W - 1) - row;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronised output, two clk edges behind d
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input combinational benchmark through rows 000..111, holds each
// row for a settle window, samples the benchmark output and assembles the
// observed truth table for comparison against EXPECTED.
// Ports:
//   clk           - single clock
//   rst           - asynchronous active-high reset
//   start         - begin a sweep; only honoured when idle or done
//   in1/in2/in3   - registered stimulus row, in1 is the MSB
//   dut_out       - benchmark output, may be asynchronous to clk
//   busy          - sweep in progress
//   done          - sweep finished, held until next start or reset
//   table_q       - observed truth table, row 000 in bit 7
//   match         - table_q equals EXPECTED, only while done
//   mismatch_mask - table_q ^ EXPECTED, only while done
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned      SETTLE_CYCLES = 16,
  parameter logic [TT_W-1:0]  EXPECTED      = 8'hB7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            in1,
  output logic            in2,
  output logic            in3,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] table_q,
  output logic            match,
  output logic [TT_W-1:0] mismatch_mask
);

  // The synchroniser eats two cycles of every settle window.
  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE_CYCLES must be within 2..255");
  end

  localparam logic [7:0] CntInit = 8'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [TT_W-1:0]    table_d;
  logic               done_q, done_d;
  logic [ROW_W-1:0]   stim_q, stim_d;
  logic               dut_s;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dut_out),
    .q   (dut_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      done_q  <= 1'b0;
      stim_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      done_q  <= done_d;
      stim_q  <= stim_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          row_d   = '0;
          cnt_d   = CntInit;
          table_d = '0;
          done_d  = 1'b0;
          state_d = StSettle;
        end else if (state_q == StDone) begin
          done_d = 1'b1;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSample: begin
        table_d[row_bit(row_q)] = dut_s;
        if (row_q == 3'd7) begin
          state_d = StDone;
        end else begin
          row_d   = row_q + 3'd1;
          cnt_d   = CntInit;
          state_d = StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Stimulus only moves when a row is entered; it holds through SAMPLE and DONE.
    stim_d = (state_d == StSettle) ? row_d : stim_q;
  end

  always_comb begin
    busy          = (state_q == StSettle) || (state_q == StSample);
    done          = done_q;
    match         = done_q && (table_q == EXPECTED);
    mismatch_mask = done_q ? (table_q ^ EXPECTED) : '0;
    in1           = stim_q[2];
    in2           = stim_q[1];
    in3           = stim_q[0];
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  localparam logic [7:0] Exp = 8'hB7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_w = '0;
  logic [2:0] dout_w;
  logic [2:0] in1_w, in2_w, in3_w, busy_w, done_w, match_w;
  logic [7:0] table_w [3];
  logic [7:0] mm_w [3];

  // Benchmark truth table per instance, same bit mapping as EXPECTED.
  logic [7:0] bench_tt [3];
  logic [2:0] dly1 [3];
  logic [2:0] dly2 [3];

  int settle_of [3] = '{4, 2, 8};
  int delay_of [3]  = '{0, 3, 3};
  int prev_row [3]  = '{0, 0, 0};

  int n_cmp = 0;
  int n_bad = 0;

  int         obs_row [$];
  logic       obs_busy [$];
  logic [8:0] obs_res [$];

  always #5 clk = ~clk;

  truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'hB7)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_w[0]), .in1(in1_w[0]), .in2(in2_w[0]), .in3(in3_w[0]),
    .dut_out(dout_w[0]), .busy(busy_w[0]), .done(done_w[0]), .table_q(table_w[0]),
    .match(match_w[0]), .mismatch_mask(mm_w[0])
  );

  truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(8'hB7)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_w[1]), .in1(in1_w[1]), .in2(in2_w[1]), .in3(in3_w[1]),
    .dut_out(dout_w[1]), .busy(busy_w[1]), .done(done_w[1]), .table_q(table_w[1]),
    .match(match_w[1]), .mismatch_mask(mm_w[1])
  );

  truth_table_sweeper #(.SETTLE_CYCLES(8), .EXPECTED(8'hB7)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_w[2]), .in1(in1_w[2]), .in2(in2_w[2]), .in3(in3_w[2]),
    .dut_out(dout_w[2]), .busy(busy_w[2]), .done(done_w[2]), .table_q(table_w[2]),
    .match(match_w[2]), .mismatch_mask(mm_w[2])
  );

  function automatic logic tt_eval(input logic [7:0] tt, input int row);
    logic [7:0] t;
    t = tt;
    return t[7-row];
  endfunction

  function automatic int row_of(input int i);
    return int'({in1_w[i], in2_w[i], in3_w[i]});
  endfunction

  // Benchmark models: instance 0 ideal, instances 1/2 see inputs three cycles late.
  always_comb begin
    dout_w[0] = tt_eval(bench_tt[0], row_of(0));
    dout_w[1] = tt_eval(bench_tt[1], int'(dly1[2]));
    dout_w[2] = tt_eval(bench_tt[2], int'(dly2[2]));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        dly1[k] <= '0;
        dly2[k] <= '0;
      end
    end else begin
      dly1[0] <= {in1_w[1], in2_w[1], in3_w[1]};
      dly1[1] <= dly1[0];
      dly1[2] <= dly1[1];
      dly2[0] <= {in1_w[2], in2_w[2], in3_w[2]};
      dly2[1] <= dly2[0];
      dly2[2] <= dly2[1];
    end
  end

  // Expected table from sweep timing: row r is sampled (r+1)*(s+1) edges after
  // start, reflecting benchmark inputs applied 2+d edges earlier.
  function automatic logic [7:0] model_table(input logic [7:0] tt, input int s, input int d,
                                             input int prev);
    logic [7:0] res;
    int t, e, seen;
    res = '0;
    for (int r = 0; r < 8; r++) begin
      t = (r + 1) * (s + 1);
      e = t - 2 - d;
      seen = (e < 0) ? prev : e / (s + 1);
      if (seen > 7) seen = 7;
      res[7-r] = tt_eval(tt, seen);
    end
    return res;
  endfunction

  function automatic int done_edge(input int s);
    return 8 * (s + 1) + 1;
  endfunction

  // Pulses start on one instance and records per-edge observations until done.
  task automatic sweep(input int idx, input int poke_n, output int done_at);
    int limit;
    limit = 8 * (settle_of[idx] + 1) + 20;
    obs_row.delete();
    obs_busy.delete();
    obs_res.delete();
    done_at = -1;
    @(negedge clk);
    start_w[idx] = 1'b1;
    @(negedge clk);
    start_w[idx] = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk);
      #1;
      start_w[idx] = 1'b0;
      obs_row.push_back(row_of(idx));
      obs_busy.push_back(busy_w[idx]);
      if (done_w[idx]) begin
        done_at = n;
        break;
      end
      obs_res.push_back({match_w[idx], mm_w[idx]});
      if (n == poke_n) start_w[idx] = 1'b1;
    end
    start_w[idx] = 1'b0;
    if (done_at > 0) prev_row[idx] = 7;
  endtask

  task automatic test_reset();
    logic [21:0] obs;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) bench_tt[i] = Exp;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      obs = {in1_w[0], in2_w[0], in3_w[0], busy_w[0], done_w[0], match_w[0], mm_w[0], table_w[0]};
      n_cmp++;
      if (obs !== '0) begin
        n_bad++;
        $display("FAIL reset_idle cycle %0d: got %h want 0", c, obs);
      end
    end
    // Mid-sweep asynchronous reset.
    @(negedge clk);
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    n_cmp++;
    if (busy_w[0] !== 1'b1 || row_of(0) != 2) begin
      n_bad++;
      $display("FAIL reset_pre busy/row: got %b/%0d want 1/2", busy_w[0], row_of(0));
    end
    rst = 1'b1;
    #1;
    obs = {in1_w[0], in2_w[0], in3_w[0], busy_w[0], done_w[0], match_w[0], mm_w[0], table_w[0]};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got %h want 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) prev_row[i] = 0;
  endtask

  task automatic test_sweep();
    int d, exp_row;
    logic [7:0] exp_t, hold_t;
    bench_tt[0] = Exp;
    sweep(0, -1, d);
    n_cmp++;
    if (d != done_edge(4)) begin
      n_bad++;
      $display("FAIL sweep_done_edge: got %0d want %0d", d, done_edge(4));
    end
    for (int n = 1; n <= obs_row.size(); n++) begin
      exp_row = (n / 5 > 7) ? 7 : n / 5;
      n_cmp++;
      if (obs_row[n-1] != exp_row || obs_busy[n-1] !== (n < 40)) begin
        n_bad++;
        $display("FAIL sweep_stim edge %0d: got row %0d busy %b want row %0d busy %b",
                 n, obs_row[n-1], obs_busy[n-1], exp_row, (n < 40));
      end
    end
    for (int k = 0; k < obs_res.size(); k++) begin
      n_cmp++;
      if (obs_res[k] !== '0) begin
        n_bad++;
        $display("FAIL sweep_result_gated edge %0d: got %h want 0", k + 1, obs_res[k]);
      end
    end
    exp_t = model_table(Exp, 4, 0, 0);
    n_cmp++;
    if (table_w[0] !== exp_t || match_w[0] !== 1'b1 || mm_w[0] !== 8'h00) begin
      n_bad++;
      $display("FAIL sweep_b7: got table %h match %b mask %h want %h 1 00",
               table_w[0], match_w[0], mm_w[0], exp_t);
    end
    hold_t = exp_t;
    repeat ($urandom_range(3, 8)) @(posedge clk);
    #1;
    n_cmp++;
    if (done_w[0] !== 1'b1 || table_w[0] !== hold_t || row_of(0) != 7) begin
      n_bad++;
      $display("FAIL sweep_hold: got done %b table %h row %0d want 1 %h 7",
               done_w[0], table_w[0], row_of(0), hold_t);
    end
    // Random benchmark functions, each swept from DONE.
    for (int k = 0; k < 4; k++) begin
      bench_tt[0] = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 4)) @(posedge clk);
      sweep(0, -1, d);
      exp_t = model_table(bench_tt[0], 4, 0, prev_row[0]);
      n_cmp++;
      if (d != done_edge(4) || table_w[0] !== exp_t || match_w[0] !== (exp_t == Exp) ||
          mm_w[0] !== (exp_t ^ Exp)) begin
        n_bad++;
        $display("FAIL sweep_rand tt %h: got done@%0d table %h match %b mask %h want %0d %h %b %h",
                 bench_tt[0], d, table_w[0], match_w[0], mm_w[0], done_edge(4), exp_t,
                 (exp_t == Exp), exp_t ^ Exp);
      end
    end
  endtask

  task automatic test_stuck();
    int d;
    logic [7:0] tts [2];
    logic [7:0] masks [2];
    tts = '{8'h00, 8'hFF};
    masks = '{8'hB7, 8'h48};
    for (int k = 0; k < 2; k++) begin
      bench_tt[0] = tts[k];
      sweep(0, -1, d);
      n_cmp++;
      if (table_w[0] !== tts[k] || match_w[0] !== 1'b0 || mm_w[0] !== masks[k]) begin
        n_bad++;
        $display("FAIL stuck_%h: got table %h match %b mask %h want %h 0 %h",
                 tts[k], table_w[0], match_w[0], mm_w[0], tts[k], masks[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int d;
    bench_tt[0] = Exp;
    sweep(0, 16, d);
    n_cmp++;
    if (d != done_edge(4) || table_w[0] !== Exp || match_w[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_poke: got done@%0d table %h match %b want %0d %h 1",
               d, table_w[0], match_w[0], done_edge(4), Exp);
    end
    @(negedge clk);
    start_w[0] = 1'b1;
    @(posedge clk);
    #1;
    start_w[0] = 1'b0;
    n_cmp++;
    if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b1 || match_w[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_rearm: got done %b busy %b match %b want 0 1 0",
               done_w[0], busy_w[0], match_w[0]);
    end
    d = -1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (done_w[0]) begin
        d = n;
        break;
      end
    end
    n_cmp++;
    if (d != done_edge(4) || table_w[0] !== Exp || match_w[0] !== 1'b1 || mm_w[0] !== 8'h00) begin
      n_bad++;
      $display("FAIL b2b_second: got done@%0d table %h match %b mask %h want %0d %h 1 00",
               d, table_w[0], match_w[0], mm_w[0], done_edge(4), Exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] obs;
    int d;
    bench_tt[0] = Exp;
    @(negedge clk);
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (27) @(posedge clk);
    #3;
    n_cmp++;
    if (row_of(0) != 5 || table_w[0] === 8'h00) begin
      n_bad++;
      $display("FAIL rstmid_pre: got row %0d table %h want row 5 nonzero", row_of(0), table_w[0]);
    end
    rst = 1'b1;
    #1;
    obs = {in1_w[0], in2_w[0], in3_w[0], busy_w[0], done_w[0], match_w[0], mm_w[0], table_w[0]};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL rstmid_clear: got %h want 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) prev_row[i] = 0;
    sweep(0, -1, d);
    n_cmp++;
    if (d != done_edge(4) || table_w[0] !== Exp || match_w[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_resweep: got done@%0d table %h match %b want %0d %h 1",
               d, table_w[0], match_w[0], done_edge(4), Exp);
    end
  endtask

  task automatic test_delayed();
    int d;
    logic [7:0] exp_t;
    for (int k = 0; k < 6; k++) begin
      int idx;
      idx = 1 + (k % 2);
      bench_tt[idx] = (k < 2) ? Exp : 8'($urandom_range(0, 255));
      exp_t = model_table(bench_tt[idx], settle_of[idx], delay_of[idx], prev_row[idx]);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      sweep(idx, -1, d);
      n_cmp++;
      if (d != done_edge(settle_of[idx]) || table_w[idx] !== exp_t ||
          match_w[idx] !== (exp_t == Exp) || mm_w[idx] !== (exp_t ^ Exp)) begin
        n_bad++;
        $display("FAIL delayed s=%0d tt %h: got done@%0d table %h match %b mask %h want %0d %h %b %h",
                 settle_of[idx], bench_tt[idx], d, table_w[idx], match_w[idx], mm_w[idx],
                 done_edge(settle_of[idx]), exp_t, (exp_t == Exp), exp_t ^ Exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_stuck();
    test_back_to_back();
    test_reset_mid();
    test_delayed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
